// File: rtl/router_fifo.sv
// router_fifo: one output FIFO of the 1x3 router.
// Each entry is {lfd, byte}. The lfd bit marks a header byte. A 6-bit
// counter follows the packet length on the read side, so the parity byte
// can be flagged with a one-cycle pkt_last pulse as it leaves.
//
// Handshake: a write is taken on an edge when write_enb=1, full=0 and
// soft_reset=0. A read is taken on an edge when read_enb=1, empty=0 and
// soft_reset=0; its byte shows up on data_out after that same edge.
// Requests that do not qualify are dropped without any side effect.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_last
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH:0]   mem [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [5:0]       count_q, count_d;
  logic             pkt_last_q, pkt_last_d;

  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH:0]   rd_entry;

  // Occupancy flags come straight from the registered pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Both requests are qualified against the flags at the start of the cycle.
  assign wr_acc   = write_enb && !full  && !soft_reset;
  assign rd_acc   = read_enb  && !empty && !soft_reset;
  assign rd_entry = mem[rd_ptr_q[AW-1:0]];

  assign data_out = data_out_q;
  assign pkt_last = pkt_last_q;

  // Storage array: no reset needed, because the pointers gate every access.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Next-state logic: soft_reset flushes; otherwise advance pointers and track the packet.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    count_d    = count_q;
    pkt_last_d = 1'b0;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      data_out_d = '0;
      count_d    = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH]) begin
          // Header: bits [7:2] hold the payload length; add one for the parity byte.
          count_d = rd_entry[7:2] + 6'd1;
        end else if (count_q != 6'd0) begin
          count_d    = count_q - 6'd1;
          pkt_last_d = (count_q == 6'd1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      count_q    <= '0;
      pkt_last_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
      pkt_last_q <= pkt_last_d;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Testbench for router_fifo: directed scenarios followed by randomized
// packet traffic. Results are checked against a queue-based reference model.
module tb_router_fifo;

  logic       clk;
  logic       resetn;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_last;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of {lfd, byte}, plus the expected outputs.
  logic [8:0] exp_q[$];
  logic [7:0] exp_data;
  bit         exp_last;
  int         mcount;

  // Random packet generator state.
  int gen_left;
  bit w_ok;

  router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty),
    .pkt_last   (pkt_last)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_out"}, {24'd0, data_out}, {24'd0, exp_data});
    check({tag, ".pkt_last"}, {31'd0, pkt_last}, {31'd0, exp_last});
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, exp_q.size() == 0});
    check({tag, ".full"}, {31'd0, full}, {31'd0, exp_q.size() == 16});
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_data = 8'h00;
    exp_last = 1'b0;
    mcount   = 0;
  endtask

  // One clock cycle. Called just after a negedge; returns just after the next negedge.
  task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                      input bit sr, input string tag, output bit wrote);
    bit m_full, m_empty, rd;
    logic [8:0] e;
    m_full  = (exp_q.size() == 16);
    m_empty = (exp_q.size() == 0);
    soft_reset = sr;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clk);
    #1;
    wrote = 1'b0;
    if (sr) begin
      model_clear();
    end else begin
      wrote    = we && !m_full;
      rd       = re && !m_empty;
      exp_last = 1'b0;
      if (rd) begin
        e = exp_q.pop_front();
        exp_data = e[7:0];
        if (e[8]) begin
          mcount = (int'(e[7:2]) + 1) % 64;
        end else if (mcount > 0) begin
          exp_last = (mcount == 1);
          mcount--;
        end
      end
      if (wrote) exp_q.push_back({lfd, din});
    end
    check_outputs(tag);
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    @(negedge clk);
  endtask

  // Random packet traffic: headers with short lengths followed by payload and parity.
  task automatic random_traffic(input int cycles, input int wr_pct, input int rd_pct);
    bit we, re, lfd;
    logic [7:0] b;
    for (int i = 0; i < cycles; i++) begin
      we = ($urandom_range(99) < wr_pct);
      re = ($urandom_range(99) < rd_pct);
      if (gen_left == 0) begin
        lfd = 1'b1;
        b   = {6'($urandom_range(1, 12)), 2'($urandom_range(3))};
      end else begin
        lfd = 1'b0;
        b   = 8'($urandom_range(255));
      end
      step(we, re, lfd, b, 1'b0, "rand", w_ok);
      if (w_ok) gen_left = lfd ? int'(b[7:2]) + 1 : gen_left - 1;
    end
  endtask

  logic [7:0] pkt_a[5];

  initial begin
    pkt_a[0] = 8'h0D; pkt_a[1] = 8'h11; pkt_a[2] = 8'h22;
    pkt_a[3] = 8'h33; pkt_a[4] = 8'h44;
    gen_left   = 0;
    resetn     = 1'b0;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    read_enb   = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    model_clear();

    // Reset state.
    repeat (2) @(negedge clk);
    check_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // A read while empty changes nothing.
    step(0, 1, 0, 8'h00, 0, "rd_empty", w_ok);

    // Single packet: header 0D, payload 11 22 33, parity 44.
    for (int i = 0; i < 5; i++) step(1, 0, (i == 0), pkt_a[i], 0, "pkt_wr", w_ok);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00, 0, "pkt_rd", w_ok);
    check("pkt_last_data", {24'd0, data_out}, 32'h44);

    // Fill to 16 entries, try a 17th write, then read and write together while full.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(8'hA0 + i), 0, "fill", w_ok);
    check("full_after_16", {31'd0, full}, 32'd1);
    step(1, 0, 0, 8'hEE, 0, "wr_full", w_ok);
    step(1, 1, 0, 8'hEF, 0, "rw_full", w_ok);
    check("rw_full_oldest", {24'd0, data_out}, 32'hA0);
    check("rw_full_notfull", {31'd0, full}, 32'd0);
    while (exp_q.size() > 0) step(0, 1, 0, 8'h00, 0, "drain", w_ok);

    // 40 bytes in interleaved bursts, forcing the pointers to wrap.
    for (int burst = 0; burst < 5; burst++) begin
      for (int i = 0; i < 8; i++) step(1, (i % 3 == 0), 0, 8'($urandom_range(255)), 0, "wrap_wr", w_ok);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 0, "wrap_rd", w_ok);
    end
    while (exp_q.size() > 0) step(0, 1, 0, 8'h00, 0, "wrap_drain", w_ok);
    check("wrap_empty", {31'd0, empty}, 32'd1);

    // Soft reset with write and read in the same cycle.
    for (int i = 0; i < 6; i++) step(1, (i == 2), 0, 8'(8'h60 + i), 0, "sr_fill", w_ok);
    step(1, 1, 0, 8'h77, 1, "soft_reset", w_ok);
    check("sr_data_zero", {24'd0, data_out}, 32'd0);
    step(1, 0, 1, 8'h08, 0, "sr_hdr_wr", w_ok);
    step(0, 1, 0, 8'h00, 0, "sr_hdr_rd", w_ok);
    check("sr_first_entry", {24'd0, data_out}, 32'h08);
    step(1, 0, 0, 8'h55, 0, "sr_tail_wr", w_ok);
    step(1, 0, 0, 8'h56, 0, "sr_tail_wr", w_ok);
    step(0, 1, 0, 8'h00, 0, "sr_tail_rd", w_ok);
    step(0, 1, 0, 8'h00, 0, "sr_tail_rd", w_ok);

    // Truncated packet: header 0D with only 2 bytes, then header 04 with 2 bytes.
    step(1, 0, 1, 8'h0D, 0, "trunc_wr", w_ok);
    step(1, 0, 0, 8'hA1, 0, "trunc_wr", w_ok);
    step(1, 0, 0, 8'hA2, 0, "trunc_wr", w_ok);
    step(1, 0, 1, 8'h04, 0, "trunc_wr", w_ok);
    step(1, 0, 0, 8'hB1, 0, "trunc_wr", w_ok);
    step(1, 0, 0, 8'hB2, 0, "trunc_wr", w_ok);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h00, 0, "trunc_rd", w_ok);
      check("trunc_no_last", {31'd0, pkt_last}, 32'd0);
    end
    step(0, 1, 0, 8'h00, 0, "trunc_last", w_ok);
    check("trunc_last_pulse", {31'd0, pkt_last}, 32'd1);

    // Randomized packet traffic with balanced, write-heavy and read-heavy phases.
    gen_left = 0;
    random_traffic(200, 50, 50);
    random_traffic(120, 80, 30);
    random_traffic(120, 30, 80);

    // Asynchronous reset mid-operation.
    random_traffic(20, 90, 10);
    #2;
    resetn = 1'b0;
    #1;
    model_clear();
    check_outputs("async_reset");
    @(negedge clk);
    resetn   = 1'b1;
    gen_left = 0;
    @(negedge clk);
    random_traffic(200, 50, 50);

    // Soft reset mid-traffic, then a final drain.
    step(0, 0, 0, 8'h00, 1, "soft_reset2", w_ok);
    gen_left = 0;
    random_traffic(100, 60, 40);
    while (exp_q.size() > 0) step(0, 1, 0, 8'h00, 0, "final_drain", w_ok);
    check("final_empty", {31'd0, empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
